fp_issue_scheduler: RTL and testbench

- Sits between the FP sub-instruction decoder and the FP execution units. Sequences the multi-cycle units (add/sub, mul, div, sqrt) and the single-cycle paths (trns, abs/opp, fmov).
- Tracks pending FP-register writes (scoreboard) and reserves the single FP register-file write port per cycle.
- Stalls issue on hazards and emits unit start pulses plus a writeback select (FP_OutPathSel source) and destination.

---
 rtl/fp_issue_scheduler_pkg.sv | 39 +++
 rtl/fp_wb_reservation.sv | 61 ++++++
 rtl/fp_issue_scheduler.sv | 135 +++++++++++++
 tb/tb_fp_issue_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_issue_scheduler_pkg.sv
// Shared FP definitions: function codes, unit latencies and the writeback
// reservation entry used by the decoder, datapath and issue scheduler.
package fp_issue_scheduler_pkg;

  typedef enum logic [2:0] {
    F_Null   = 3'd0,
    F_Trns   = 3'd1,
    F_AddSub = 3'd2,
    F_Mul    = 3'd3,
    F_Div    = 3'd4,
    F_Sqrt   = 3'd5,
    F_AbsOpp = 3'd6
  } fp_fun_e;

  localparam int unsigned ADD_LAT     = 3;
  localparam int unsigned MUL_LAT     = 4;
  localparam int unsigned DIV_CYC     = 24;
  localparam int unsigned SQRT_CYC    = 26;
  localparam int unsigned TABLE_DEPTH = 31;

  typedef struct packed {
    logic       valid;
    logic [2:0] fun;
    logic [3:0] wn;
  } wb_entry_t;

  // Zero marks a code that is not a real operation (F_Null or unused).
  function automatic logic [4:0] fun_latency(input logic [2:0] fun);
    case (fun)
      F_Trns, F_AbsOpp: fun_latency = 5'd1;
      F_AddSub:         fun_latency = 5'(ADD_LAT);
      F_Mul:            fun_latency = 5'(MUL_LAT);
      F_Div:            fun_latency = 5'(DIV_CYC);
      F_Sqrt:           fun_latency = 5'(SQRT_CYC);
      default:          fun_latency = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/fp_wb_reservation.sv
// Shift-register reservation table for the single FP register-file write port.
// slots[k] holds the op whose writeback register loads k edges from now.
module fp_wb_reservation
  import fp_issue_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       reserve,
  input  logic [4:0] lat,
  input  logic [2:0] fun,
  input  logic [3:0] wn,
  input  logic [4:0] query_lat,
  output logic       occupied,
  output logic       head_valid,
  output logic [2:0] head_fun,
  output logic [3:0] head_wn
);

  wb_entry_t slots [1:TABLE_DEPTH];
  wb_entry_t head;
  wb_entry_t new_entry;

  assign new_entry  = '{valid: 1'b1, fun: fun, wn: wn};
  assign head_valid = head.valid;
  assign head_fun   = head.fun;
  assign head_wn    = head.wn;

  // An op of latency L accepted now lands in slots[L-1] after the shift,
  // so the slot it competes for is the one currently at index L.
  always_comb begin
    occupied = 1'b0;
    if (query_lat != 5'd0) begin
      occupied = slots[query_lat].valid;
    end else begin
      occupied = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      for (int k = 1; k <= TABLE_DEPTH; k++) slots[k] <= '0;
    end else if (clr) begin
      head <= '0;
      for (int k = 1; k <= TABLE_DEPTH; k++) slots[k] <= '0;
    end else begin
      head <= slots[1];
      for (int k = 1; k < TABLE_DEPTH; k++) slots[k] <= slots[k+1];
      slots[TABLE_DEPTH] <= '0;
      if (reserve) begin
        if (lat == 5'd1) begin
          head <= new_entry;
        end else if (lat >= 5'd2) begin
          slots[lat - 5'd1] <= new_entry;
        end
      end
    end
  end

endmodule

// File: rtl/fp_issue_scheduler.sv
// FP issue scheduler: scoreboard, hazard stall, unit start pulses and
// writeback-port sequencing for the multi-cycle and single-cycle FP paths.
module fp_issue_scheduler
  import fp_issue_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [2:0] issue_fun,
  input  logic       issue_wreg,
  input  logic [3:0] issue_wn,
  input  logic [3:0] issue_rna,
  input  logic [3:0] issue_rnb,
  input  logic       issue_useb,
  input  logic       flush,
  output logic       stall,
  output logic       add_start,
  output logic       mul_start,
  output logic       div_start,
  output logic       sqrt_start,
  output logic       wb_valid,
  output logic [2:0] wb_sel,
  output logic [3:0] wb_wn,
  output logic       div_busy,
  output logic       sqrt_busy
);

  logic [15:0] pending;
  logic [15:0] pending_next;
  logic [4:0]  div_cnt;
  logic [4:0]  sqrt_cnt;
  logic [4:0]  lat;
  logic        is_op;
  logic        hazard;
  logic        accept;
  logic        occupied;

  assign div_busy  = (div_cnt != 5'd0);
  assign sqrt_busy = (sqrt_cnt != 5'd0);

  always_comb begin
    lat    = fun_latency(issue_fun);
    is_op  = (lat != 5'd0);
    hazard = pending[issue_rna]
           | (issue_useb & pending[issue_rnb])
           | (issue_wreg & pending[issue_wn])
           | ((issue_fun == F_Div) & div_busy)
           | ((issue_fun == F_Sqrt) & sqrt_busy)
           | (issue_wreg & occupied);
    stall  = issue_valid & is_op & hazard;
    accept = issue_valid & is_op & ~hazard & ~flush;
  end

  fp_wb_reservation u_resv (
    .clk        (clk),
    .rst        (reset),
    .clr        (flush),
    .reserve    (accept & issue_wreg),
    .lat        (lat),
    .fun        (issue_fun),
    .wn         (issue_wn),
    .query_lat  (lat),
    .occupied   (occupied),
    .head_valid (wb_valid),
    .head_fun   (wb_sel),
    .head_wn    (wb_wn)
  );

  // Clear the completing destination first, then mark the newly accepted one.
  always_comb begin
    pending_next = pending;
    if (wb_valid) begin
      pending_next[wb_wn] = 1'b0;
    end else begin
      pending_next = pending;
    end
    if (accept & issue_wreg) begin
      pending_next[issue_wn] = 1'b1;
    end else begin
      pending_next = pending_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 16'd0;
    end else if (flush) begin
      pending <= 16'd0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_start  <= 1'b0;
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      sqrt_start <= 1'b0;
    end else begin
      add_start  <= accept & (issue_fun == F_AddSub);
      mul_start  <= accept & (issue_fun == F_Mul);
      div_start  <= accept & (issue_fun == F_Div);
      sqrt_start <= accept & (issue_fun == F_Sqrt);
    end
  end

  // Busy counters run independently of issue_wreg, reaching zero at the
  // edge that ends the unit's writeback cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= 5'd0;
      sqrt_cnt <= 5'd0;
    end else if (flush) begin
      div_cnt  <= 5'd0;
      sqrt_cnt <= 5'd0;
    end else begin
      if (accept & (issue_fun == F_Div)) begin
        div_cnt <= 5'(DIV_CYC);
      end else if (div_cnt != 5'd0) begin
        div_cnt <= div_cnt - 5'd1;
      end else begin
        div_cnt <= div_cnt;
      end
      if (accept & (issue_fun == F_Sqrt)) begin
        sqrt_cnt <= 5'(SQRT_CYC);
      end else if (sqrt_cnt != 5'd0) begin
        sqrt_cnt <= sqrt_cnt - 5'd1;
      end else begin
        sqrt_cnt <= sqrt_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Directed self-checking bench for fp_issue_scheduler with hand-computed
// cycle-by-cycle expectations.
module tb_fp_issue_scheduler;
  import fp_issue_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [2:0] issue_fun;
  logic       issue_wreg;
  logic [3:0] issue_wn;
  logic [3:0] issue_rna;
  logic [3:0] issue_rnb;
  logic       issue_useb;
  logic       flush;
  logic       stall;
  logic       add_start, mul_start, div_start, sqrt_start;
  logic       wb_valid;
  logic [2:0] wb_sel;
  logic [3:0] wb_wn;
  logic       div_busy, sqrt_busy;

  int errors = 0;
  int checks = 0;

  fp_issue_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_fun   (issue_fun),
    .issue_wreg  (issue_wreg),
    .issue_wn    (issue_wn),
    .issue_rna   (issue_rna),
    .issue_rnb   (issue_rnb),
    .issue_useb  (issue_useb),
    .flush       (flush),
    .stall       (stall),
    .add_start   (add_start),
    .mul_start   (mul_start),
    .div_start   (div_start),
    .sqrt_start  (sqrt_start),
    .wb_valid    (wb_valid),
    .wb_sel      (wb_sel),
    .wb_wn       (wb_wn),
    .div_busy    (div_busy),
    .sqrt_busy   (sqrt_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic w,
                       input logic [3:0] wn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic ub);
    issue_valid = v;
    issue_fun   = f;
    issue_wreg  = w;
    issue_wn    = wn;
    issue_rna   = ra;
    issue_rnb   = rb;
    issue_useb  = ub;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, F_Null, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [2:0] s, input logic [3:0] n);
    chk({tag, "_valid"}, 32'(wb_valid), 32'(v));
    if (v) begin
      chk({tag, "_sel"}, 32'(wb_sel), 32'(s));
      chk({tag, "_wn"},  32'(wb_wn),  32'(n));
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb", 32'(wb_valid), 32'd0);
    chk("rst_starts", 32'({add_start, mul_start, div_start, sqrt_start}), 32'd0);
    chk("rst_busy", 32'({div_busy, sqrt_busy}), 32'd0);
    reset = 1'b0;

    // FADD F1 <- F2,F3, then a transfer reading F1
    tick(); drive(1'b1, F_AddSub, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1);
    chk("add_c0_stall", 32'(stall), 32'd0);
    tick(); idle();
    chk("add_c1_start", 32'(add_start), 32'd1);
    chk_wb("add_c1_wb", 1'b0, F_Null, 4'd0);
    tick();
    chk("add_c2_start", 32'(add_start), 32'd0);
    tick(); drive(1'b1, F_Trns, 1'b1, 4'd11, 4'd1, 4'd0, 1'b0);
    chk_wb("add_c3_wb", 1'b1, F_AddSub, 4'd1);
    chk("raw_c3_stall", 32'(stall), 32'd1);
    tick();
    chk_wb("add_c4_wb", 1'b0, F_Null, 4'd0);
    chk("raw_c4_stall", 32'(stall), 32'd0);
    tick(); idle();
    chk_wb("trns_wb", 1'b1, F_Trns, 4'd11);
    tick();
    chk_wb("trns_after", 1'b0, F_Null, 4'd0);

    // FMUL F4 then FADD F5 colliding on the write port
    tick(); drive(1'b1, F_Mul, 1'b1, 4'd4, 4'd0, 4'd0, 1'b1);
    chk("mul_c0_stall", 32'(stall), 32'd0);
    tick(); drive(1'b1, F_AddSub, 1'b1, 4'd5, 4'd2, 4'd3, 1'b1);
    chk("mul_c1_start", 32'(mul_start), 32'd1);
    chk("port_c1_stall", 32'(stall), 32'd1);
    tick();
    chk("port_c2_stall", 32'(stall), 32'd0);
    chk("mul_c2_start", 32'(mul_start), 32'd0);
    tick(); idle();
    chk("port_c3_addstart", 32'(add_start), 32'd1);
    tick();
    chk_wb("mul_c4_wb", 1'b1, F_Mul, 4'd4);
    tick();
    chk_wb("add_c5_wb", 1'b1, F_AddSub, 4'd5);
    tick();
    chk_wb("port_c6_wb", 1'b0, F_Null, 4'd0);

    // FDIV F6 then FADD F7 <- F6,F0
    tick(); drive(1'b1, F_Div, 1'b1, 4'd6, 4'd0, 4'd0, 1'b0);
    chk("div_c0_stall", 32'(stall), 32'd0);
    tick(); drive(1'b1, F_AddSub, 1'b1, 4'd7, 4'd6, 4'd0, 1'b1);
    chk("div_c1_start", 32'(div_start), 32'd1);
    chk("div_c1_busy", 32'(div_busy), 32'd1);
    chk("div_c1_stall", 32'(stall), 32'd1);
    for (int c = 2; c <= 24; c++) begin
      tick();
      chk($sformatf("div_raw_c%0d_stall", c), 32'(stall), 32'd1);
      if (c == 24) chk_wb("div_c24_wb", 1'b1, F_Div, 4'd6);
      else chk_wb($sformatf("div_c%0d_nowb", c), 1'b0, F_Null, 4'd0);
    end
    tick();
    chk("div_c25_stall", 32'(stall), 32'd0);
    chk("div_c25_busy", 32'(div_busy), 32'd0);
    tick(); idle();
    chk("div_c26_addstart", 32'(add_start), 32'd1);
    tick();
    tick();
    chk_wb("div_c28_addwb", 1'b1, F_AddSub, 4'd7);

    // Back-to-back FDIV F8, F9 (structural), cleaned up by a flush
    tick(); drive(1'b1, F_Div, 1'b1, 4'd8, 4'd0, 4'd0, 1'b0);
    chk("div2_c0_stall", 32'(stall), 32'd0);
    tick(); drive(1'b1, F_Div, 1'b1, 4'd9, 4'd0, 4'd0, 1'b0);
    chk("div2_c1_stall", 32'(stall), 32'd1);
    for (int c = 2; c <= 24; c++) begin
      tick();
      chk($sformatf("div2_c%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("div2_c%0d_busy", c), 32'(div_busy), 32'd1);
    end
    chk_wb("div2_c24_wb", 1'b1, F_Div, 4'd8);
    tick();
    chk("div2_c25_stall", 32'(stall), 32'd0);
    tick(); idle(); flush = 1'b1;
    chk("div2_c26_start", 32'(div_start), 32'd1);
    chk("div2_c26_busy", 32'(div_busy), 32'd1);
    tick(); flush = 1'b0;
    chk("flush_div_busy", 32'(div_busy), 32'd0);
    chk_wb("flush_div_wb", 1'b0, F_Null, 4'd0);

    // FMUL F10 flushed at cycle 2, then FADD F12 <- F10 accepted at cycle 3
    tick(); drive(1'b1, F_Mul, 1'b1, 4'd10, 4'd0, 4'd0, 1'b0);
    tick(); idle();
    chk("fl_c1_mulstart", 32'(mul_start), 32'd1);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; drive(1'b1, F_AddSub, 1'b1, 4'd12, 4'd10, 4'd0, 1'b1);
    chk("fl_c3_stall", 32'(stall), 32'd0);
    tick(); idle();
    chk_wb("fl_c4_nowb", 1'b0, F_Null, 4'd0);
    chk("fl_c4_addstart", 32'(add_start), 32'd1);
    tick();
    chk_wb("fl_c5_nowb", 1'b0, F_Null, 4'd0);
    tick();
    chk_wb("fl_c6_addwb", 1'b1, F_AddSub, 4'd12);

    // Flush in the same cycle as an issue: op is dropped, no start pulse
    tick(); drive(1'b1, F_Mul, 1'b1, 4'd13, 4'd0, 4'd0, 1'b0); flush = 1'b1;
    tick(); flush = 1'b0; drive(1'b1, F_Trns, 1'b0, 4'd0, 4'd13, 4'd0, 1'b0);
    chk("flacc_mulstart", 32'(mul_start), 32'd0);
    chk("flacc_stall", 32'(stall), 32'd0);
    tick(); idle();
    chk_wb("flacc_nowb", 1'b0, F_Null, 4'd0);

    // FSQRT F15 interrupted by async reset at cycle 10
    tick(); drive(1'b1, F_Sqrt, 1'b1, 4'd15, 4'd0, 4'd0, 1'b0);
    chk("sq_c0_stall", 32'(stall), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      tick(); idle();
      if (c == 1) chk("sq_c1_start", 32'(sqrt_start), 32'd1);
    end
    chk("sq_c10_busy", 32'(sqrt_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("sq_rst_busy", 32'(sqrt_busy), 32'd0);
    chk("sq_rst_outs", 32'({stall, add_start, mul_start, div_start, sqrt_start, wb_valid, div_busy}), 32'd0);
    tick(); reset = 1'b0; drive(1'b1, F_Sqrt, 1'b1, 4'd15, 4'd0, 4'd0, 1'b0);
    chk("sq_r0_stall", 32'(stall), 32'd0);
    tick(); idle();
    chk("sq_r1_start", 32'(sqrt_start), 32'd1);
    chk("sq_r1_busy", 32'(sqrt_busy), 32'd1);
    for (int c = 2; c <= 26; c++) begin
      tick();
      if (c == 26) chk_wb("sq_r26_wb", 1'b1, F_Sqrt, 4'd15);
      else chk_wb($sformatf("sq_r%0d_nowb", c), 1'b0, F_Null, 4'd0);
    end
    tick();
    chk("sq_r27_busy", 32'(sqrt_busy), 32'd0);
    chk_wb("sq_r27_nowb", 1'b0, F_Null, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
